clint_mh: RTL and testbench



---
 rtl/clint_mh_pkg.sv | 25 ++
 rtl/clint_mh_timer.sv | 47 ++++
 rtl/clint_mh.sv | 139 +++++++++++++
 tb/tb_clint_mh.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_mh_pkg.sv
// clint_mh shared definitions: register offsets,
// interrupt cause codes and the byte-strobe merge helper.
package clint_mh_pkg;

  localparam logic [15:0] MSIP_OFS     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFS = 16'h4000;
  localparam logic [15:0] MTIME_OFS    = 16'hBFF8;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;

  function automatic logic [31:0] strb_merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/clint_mh_timer.sv
// Prescaler plus 64-bit mtime with word write ports.
// Ports: clk/rst_n, wr_lo/wr_hi + wstrb/wdata, mtime, tick.
module clint_mh_timer
  import clint_mh_pkg::*;
#(
  parameter logic [31:0] TICK_CNT = 32'd100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic [63:0] mtime,
  output logic        tick
);

  logic [31:0] presc;

  assign tick = (presc == TICK_CNT - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 32'd1;
    end
  end

  // A CPU write to either word suppresses the
  // increment for that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo)
        mtime[31:0] <= strb_merge(mtime[31:0], wdata, wstrb);
      if (wr_hi)
        mtime[63:32] <= strb_merge(mtime[63:32], wdata, wstrb);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

endmodule

// File: rtl/clint_mh.sv
// Multi-hart CLINT: msip/mtimecmp per hart, shared mtime.
// Ports: bus read (RDEN..RDATA), write (WREN..WDATA), INT_EN/INT_CODE.
module clint_mh
  import clint_mh_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          HART_NUM  = 1,
  parameter logic [31:0] TICK_CNT  = 32'd100
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  RDEN,
  input  logic [31:0]           RIADDR,
  output logic [31:0]           ROADDR,
  output logic                  RVALID,
  output logic [31:0]           RDATA,
  input  logic                  WREN,
  input  logic [3:0]            WSTRB,
  input  logic [31:0]           WADDR,
  input  logic [31:0]           WDATA,
  output logic [HART_NUM-1:0]   INT_EN,
  output logic [4*HART_NUM-1:0] INT_CODE
);

  localparam logic [13:0] MT_LO_W = MTIME_OFS[15:2];
  localparam logic [13:0] MT_HI_W = MTIME_OFS[15:2] + 14'd1;

  logic                     w_hit;
  logic                     r_hit;
  logic [13:0]              w_word;
  logic [13:0]              r_word;
  logic [63:0]              mtime;
  logic                     tick;
  logic [HART_NUM-1:0]      msip;
  logic [HART_NUM-1:0][63:0] cmp;
  logic [31:0]              rd_data;
  logic                     unused_ok;

  assign w_hit  = WREN && (WADDR[31:16] == BASE_ADDR[31:16]);
  assign r_hit  = RDEN && (RIADDR[31:16] == BASE_ADDR[31:16]);
  assign w_word = WADDR[15:2];
  assign r_word = RIADDR[15:2];

  assign unused_ok = ^{WADDR[1:0], RIADDR[1:0], tick};

  clint_mh_timer #(
    .TICK_CNT (TICK_CNT)
  ) u_timer (
    .clk   (CLK),
    .rst_n (RST_N),
    .wr_lo (w_hit && (w_word == MT_LO_W)),
    .wr_hi (w_hit && (w_word == MT_HI_W)),
    .wstrb (WSTRB),
    .wdata (WDATA),
    .mtime (mtime),
    .tick  (tick)
  );

  for (genvar h = 0; h < HART_NUM; h++) begin : g_hart
    localparam logic [13:0] MSIP_W =
      MSIP_OFS[15:2] + 14'(h);
    localparam logic [13:0] CMP_W =
      MTIMECMP_OFS[15:2] + 14'(2 * h);

    logic        msip_r;
    logic [63:0] cmp_r;
    logic        mtip;
    logic        en_r;
    logic [3:0]  code_r;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        msip_r <= 1'b0;
        cmp_r  <= '1;
      end else begin
        if (w_hit && (w_word == MSIP_W) && WSTRB[0])
          msip_r <= WDATA[0];
        if (w_hit && (w_word == CMP_W))
          cmp_r[31:0] <= strb_merge(cmp_r[31:0], WDATA, WSTRB);
        if (w_hit && (w_word == CMP_W + 14'd1))
          cmp_r[63:32] <= strb_merge(cmp_r[63:32], WDATA, WSTRB);
      end
    end

    assign mtip = (mtime >= cmp_r);

    // Software interrupt outranks the timer.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        en_r   <= 1'b0;
        code_r <= '0;
      end else if (msip_r) begin
        en_r   <= 1'b1;
        code_r <= CAUSE_MSI;
      end else if (mtip) begin
        en_r   <= 1'b1;
        code_r <= CAUSE_MTI;
      end else begin
        en_r   <= 1'b0;
        code_r <= '0;
      end
    end

    assign msip[h]            = msip_r;
    assign cmp[h]             = cmp_r;
    assign INT_EN[h]          = en_r;
    assign INT_CODE[4*h +: 4] = code_r;
  end

  always_comb begin
    rd_data = '0;
    for (int h = 0; h < HART_NUM; h++) begin
      if (r_word == MSIP_OFS[15:2] + 14'(h))
        rd_data = {31'b0, msip[h]};
      if (r_word == MTIMECMP_OFS[15:2] + 14'(2 * h))
        rd_data = cmp[h][31:0];
      if (r_word == MTIMECMP_OFS[15:2] + 14'(2 * h + 1))
        rd_data = cmp[h][63:32];
    end
    if (r_word == MT_LO_W) rd_data = mtime[31:0];
    if (r_word == MT_HI_W) rd_data = mtime[63:32];
  end

  // Misses leave RDATA/ROADDR holding the last hit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RVALID <= 1'b0;
      RDATA  <= '0;
      ROADDR <= '0;
    end else begin
      RVALID <= r_hit;
      if (r_hit) begin
        RDATA  <= rd_data;
        ROADDR <= RIADDR;
      end
    end
  end

endmodule

// File: tb/tb_clint_mh.sv
// Self-checking bench for clint_mh (2 harts, TICK_CNT=4).
// Table vectors, directed sequences, then random traffic.
module tb_clint_mh;

  localparam int H = 2;
  localparam int T = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        RDEN = 1'b0;
  logic [31:0] RIADDR = '0;
  logic [31:0] ROADDR;
  logic        RVALID;
  logic [31:0] RDATA;
  logic        WREN = 1'b0;
  logic [3:0]  WSTRB = '0;
  logic [31:0] WADDR = '0;
  logic [31:0] WDATA = '0;
  logic [H-1:0]   INT_EN;
  logic [4*H-1:0] INT_CODE;

  clint_mh #(
    .BASE_ADDR (32'h0200_0000),
    .HART_NUM  (H),
    .TICK_CNT  (32'(T))
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .RDEN     (RDEN),
    .RIADDR   (RIADDR),
    .ROADDR   (ROADDR),
    .RVALID   (RVALID),
    .RDATA    (RDATA),
    .WREN     (WREN),
    .WSTRB    (WSTRB),
    .WADDR    (WADDR),
    .WDATA    (WDATA),
    .INT_EN   (INT_EN),
    .INT_CODE (INT_CODE)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  logic        m_msip [H];
  logic [63:0] m_cmp  [H];
  logic [63:0] m_time;
  int          m_cyc;
  logic [31:0] e_rdata;
  logic [31:0] e_roaddr;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic hit(input logic [31:0] a);
    return a[31:16] == 16'h0200;
  endfunction

  function automatic logic [31:0] mrg(input logic [31:0] o,
                                      input logic [31:0] d,
                                      input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int o;
    int hh;
    if (!hit(a)) return 32'h0;
    o = int'(a[15:0]) & ~3;
    if (o < 4 * H) return {31'b0, m_msip[o / 4]};
    if (o >= 'h4000 && o < 'h4000 + 8 * H) begin
      hh = (o - 'h4000) / 8;
      if ((o - 'h4000) % 8 == 0) return m_cmp[hh][31:0];
      return m_cmp[hh][63:32];
    end
    if (o == 'hBFF8) return m_time[31:0];
    if (o == 'hBFFC) return m_time[63:32];
    return 32'h0;
  endfunction

  function automatic logic [3:0] m_code(input int h);
    if (m_msip[h]) return 4'd3;
    if (m_time >= m_cmp[h]) return 4'd7;
    return 4'd0;
  endfunction

  task automatic model_reset();
    for (int h = 0; h < H; h++) begin
      m_msip[h] = 1'b0;
      m_cmp[h]  = '1;
    end
    m_time   = '0;
    m_cyc    = 0;
    e_rdata  = '0;
    e_roaddr = '0;
  endtask

  task automatic m_update(input logic wr, input logic [31:0] wa,
                          input logic [3:0] st, input logic [31:0] wd);
    int o;
    int hh;
    logic tw;
    logic tk;
    tw = 1'b0;
    if (wr && hit(wa)) begin
      o = int'(wa[15:0]) & ~3;
      if (o < 4 * H) begin
        if (st[0]) m_msip[o / 4] = wd[0];
      end else if (o >= 'h4000 && o < 'h4000 + 8 * H) begin
        hh = (o - 'h4000) / 8;
        if ((o - 'h4000) % 8 == 0)
          m_cmp[hh][31:0] = mrg(m_cmp[hh][31:0], wd, st);
        else
          m_cmp[hh][63:32] = mrg(m_cmp[hh][63:32], wd, st);
      end else if (o == 'hBFF8) begin
        m_time[31:0] = mrg(m_time[31:0], wd, st);
        tw = 1'b1;
      end else if (o == 'hBFFC) begin
        m_time[63:32] = mrg(m_time[63:32], wd, st);
        tw = 1'b1;
      end
    end
    tk = (m_cyc % T) == T - 1;
    m_cyc++;
    if (tk && !tw) m_time = m_time + 64'd1;
  endtask

  task automatic cyc(input logic rd, input logic [31:0] ra,
                     input logic wr, input logic [31:0] wa,
                     input logic [3:0] st, input logic [31:0] wd);
    logic ev;
    logic [H-1:0] een;
    logic [4*H-1:0] ecode;
    RDEN = rd; RIADDR = ra;
    WREN = wr; WADDR = wa; WSTRB = st; WDATA = wd;
    ev = rd && hit(ra);
    if (ev) begin
      e_rdata  = m_read(ra);
      e_roaddr = ra;
    end
    for (int h = 0; h < H; h++) begin
      ecode[4*h +: 4] = m_code(h);
      een[h] = (m_code(h) != 4'd0);
    end
    @(posedge CLK);
    #1;
    m_update(wr, wa, st, wd);
    chk("rvalid", 64'(RVALID), 64'(ev));
    chk("rdata", 64'(RDATA), 64'(e_rdata));
    chk("roaddr", 64'(ROADDR), 64'(e_roaddr));
    chk("int_en", 64'(INT_EN), 64'(een));
    chk("int_code", 64'(INT_CODE), 64'(ecode));
    RDEN = 1'b0;
    WREN = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(1'b1, a, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s,
                    input logic [31:0] d);
    cyc(1'b0, 32'h0, 1'b1, a, s, d);
  endtask

  task automatic do_reset();
    RDEN = 1'b0;
    WREN = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("rst_rvalid", 64'(RVALID), 64'h0);
    chk("rst_rdata", 64'(RDATA), 64'h0);
    chk("rst_roaddr", 64'(ROADDR), 64'h0);
    chk("rst_int_en", 64'(INT_EN), 64'h0);
    chk("rst_int_code", 64'(INT_CODE), 64'h0);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        v;
    logic [31:0] d;
  } vec_t;

  vec_t tbl [9];
  logic [31:0] alist [13];

  initial begin
    int n;
    tbl[0] = '{32'h0200_BFF8, 1'b1, 32'h0};
    tbl[1] = '{32'h0200_BFFC, 1'b1, 32'h0};
    tbl[2] = '{32'h0200_4000, 1'b1, 32'hFFFF_FFFF};
    tbl[3] = '{32'h0200_400C, 1'b1, 32'hFFFF_FFFF};
    tbl[4] = '{32'h0200_0004, 1'b1, 32'h0};
    tbl[5] = '{32'h0200_0010, 1'b1, 32'h0};
    tbl[6] = '{32'h0300_0000, 1'b0, 32'h0};
    tbl[7] = '{32'h0200_4010, 1'b1, 32'h0};
    tbl[8] = '{32'h0200_0008, 1'b1, 32'h0};
    alist = '{32'h0200_0000, 32'h0200_0004, 32'h0200_0008,
              32'h0200_4000, 32'h0200_4004, 32'h0200_4008,
              32'h0200_400C, 32'h0200_4010, 32'h0200_BFF8,
              32'h0200_BFFC, 32'h0300_0000, 32'h0200_0010,
              32'h0200_BFF0};

    do_reset();

    // Reset-state reads and window decode
    for (int i = 0; i < 9; i++) begin
      rd(tbl[i].addr);
      chk("tbl_valid", 64'(RVALID), 64'(tbl[i].v));
      if (tbl[i].v) chk("tbl_data", 64'(RDATA), 64'(tbl[i].d));
    end

    // mtime counting
    do_reset();
    repeat (40) idle();
    rd(32'h0200_BFF8);
    chk("mtime_cnt_valid", 64'(RVALID), 64'h1);
    chk("mtime_cnt_range",
        64'(RDATA >= 32'd9 && RDATA <= 32'd11), 64'h1);
    chk("mtime_cnt_addr", 64'(ROADDR), 64'h0200_BFF8);

    // Timer interrupt on hart 1
    wr(32'h0200_4008, 4'hF, 32'd5);
    wr(32'h0200_400C, 4'hF, 32'd0);
    n = 0;
    while (!INT_EN[1] && n < 200) begin
      idle();
      n++;
    end
    chk("mtip_wait", 64'(n < 200), 64'h1);
    chk("mtip_en", 64'(INT_EN), 64'h2);
    chk("mtip_code", 64'(INT_CODE[7:4]), 64'h7);
    wr(32'h0200_400C, 4'hF, 32'd1);
    chk("mtip_hold", 64'(INT_EN[1]), 64'h1);
    idle();
    chk("mtip_drop", 64'(INT_EN[1]), 64'h0);

    // Priority on hart 0
    wr(32'h0200_4000, 4'hF, 32'd0);
    wr(32'h0200_4004, 4'hF, 32'd0);
    idle();
    idle();
    chk("prio_mti", 64'(INT_CODE[3:0]), 64'h7);
    wr(32'h0200_0000, 4'hF, 32'd1);
    idle();
    chk("prio_msi", 64'(INT_CODE[3:0]), 64'h3);
    wr(32'h0200_0000, 4'hF, 32'd0);
    idle();
    chk("prio_back", 64'(INT_CODE[3:0]), 64'h7);

    // Strobed write colliding with a tick
    wr(32'h0200_BFFC, 4'hF, 32'd0);
    while (m_cyc % T != 0) idle();
    wr(32'h0200_BFF8, 4'hF, 32'h0000_00FF);
    idle();
    idle();
    chk("coll_phase", 64'(m_cyc % T), 64'(T - 1));
    wr(32'h0200_BFF8, 4'b0001, 32'h1234_56AA);
    rd(32'h0200_BFF8);
    chk("coll_lo", 64'(RDATA), 64'h0000_00AA);
    rd(32'h0200_BFFC);
    chk("coll_hi", 64'(RDATA), 64'h0);

    // Carry into the high word
    while (m_cyc % T != 0) idle();
    wr(32'h0200_BFF8, 4'hF, 32'hFFFF_FFFF);
    repeat (3) idle();
    rd(32'h0200_BFFC);
    chk("carry_hi", 64'(RDATA), 64'h1);
    rd(32'h0200_BFF8);
    chk("carry_lo", 64'(RDATA), 64'h0);

    // Window miss holds previous return
    rd(32'h0300_0000);
    chk("miss_valid", 64'(RVALID), 64'h0);
    chk("miss_hold", 64'(ROADDR), 64'h0200_BFF8);

    // Reset during an in-flight read
    rd(32'h0200_BFF8);
    chk("pre_rst_valid", 64'(RVALID), 64'h1);
    do_reset();
    rd(32'h0200_4000);
    chk("post_rst_cmp_lo", 64'(RDATA), 64'hFFFF_FFFF);
    rd(32'h0200_400C);
    chk("post_rst_cmp_hi", 64'(RDATA), 64'hFFFF_FFFF);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      logic [31:0] d;
      d = ($urandom % 2) ? 32'($urandom_range(0, 40)) : $urandom;
      cyc(1'($urandom % 2), alist[$urandom % 13],
          1'($urandom % 3 == 0), alist[$urandom % 13],
          4'($urandom), d);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
